// File: rtl/mppc_pkg.sv
// Shared types, defaults and helpers for the MPPC coincidence counter.
package mppc_pkg;

  typedef enum logic [1:0] {IDLE, OPEN, EVAL} coinc_st_e;

  localparam int N_CH_DEF     = 8;
  localparam int CNT_W_DEF    = 16;
  localparam int WINDOW_DEF   = 8;
  localparam int MIN_FOLD_DEF = 2;
  localparam int BOOT_W_DEF   = 17;
  localparam int DEAD_CYC_DEF = 16;

  // Widest channel pattern the fold counter handles.
  localparam int POP_MAX = 64;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mppc_chan.sv
// One MPPC channel: synchroniser, rising-edge HIT, saturating hit counter.
// MPPC_DEADTIME_EN adds a per-channel retrigger dead time of DEAD_CYC cycles.
module mppc_chan
  import mppc_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ch_in,
  input  logic             booted,
  input  logic             clr,
  output logic             hit,
  output logic [CNT_W-1:0] cnt
);

  logic s1, s2, s3;
  logic hit_nx;

  // Held at zero until the pads have been discharged.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
    end else if (!booted) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
    end else begin
      s1 <= ch_in; s2 <= s1; s3 <= s2;
    end
  end

`ifdef MPPC_DEADTIME_EN
  localparam int DW = $clog2(DEAD_CYC + 1);
  logic [DW-1:0] dead;

  assign hit_nx = s2 & ~s3 & (dead == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)           dead <= '0;
    else if (hit_nx)      dead <= DW'(DEAD_CYC);
    else if (dead != '0)  dead <= dead - DW'(1);
  end
`else
  assign hit_nx = s2 & ~s3;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) hit <= 1'b0;
    else        hit <= hit_nx;
  end

  // Clear beats a simultaneous hit; count sticks at all-ones.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (hit && cnt != '1)   cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/mppc_coinc_counter.sv
// MPPC front-end: boot discharge, per-channel counters, sliding coincidence window, readout.
// Optional define MPPC_DEADTIME_EN enables per-channel dead time in mppc_chan.
module mppc_coinc_counter
  import mppc_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WINDOW   = WINDOW_DEF,
  parameter int MIN_FOLD = MIN_FOLD_DEF,
  parameter int BOOT_W   = BOOT_W_DEF,
  parameter int DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [N_CH-1:0]             CH_IN,
  input  logic [N_CH-1:0]             CH_MASK,
  input  logic                        CLR,
  input  logic [$clog2(N_CH+1)-1:0]   RD_SEL,
  output logic [CNT_W-1:0]            RD_DATA,
  output logic                        DISCHARGE,
  output logic                        BOOTED,
  output logic [N_CH-1:0]             HIT,
  output logic                        COINC,
  output logic [N_CH-1:0]             COINC_PAT
);

  localparam int SEL_W = $clog2(N_CH + 1);
  localparam int WCW   = $clog2(WINDOW + 1);

  // Boot timer freezes once its top bit sets; that bit is the booted flag.
  logic [BOOT_W-1:0] boot_t;
  logic              booted;

  assign booted    = boot_t[BOOT_W-1];
  assign BOOTED    = booted;
  assign DISCHARGE = ~booted;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       boot_t <= '0;
    else if (!booted) boot_t <= boot_t + BOOT_W'(1);
  end

  logic [N_CH-1:0][CNT_W-1:0] cnt;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    mppc_chan #(.CNT_W(CNT_W), .DEAD_CYC(DEAD_CYC)) u_ch (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .ch_in  (CH_IN[gi]),
      .booted (booted),
      .clr    (CLR),
      .hit    (HIT[gi]),
      .cnt    (cnt[gi])
    );
  end

  // Coincidence window: the seeding cycle plus WINDOW-1 OPEN cycles, then EVAL.
  coinc_st_e       state, nstate;
  logic [N_CH-1:0] mhit, pattern, pat_nx;
  logic [WCW-1:0]  wcnt, wcnt_nx;
  logic            coinc;
  logic [CNT_W-1:0] coinc_cnt;

  assign mhit = HIT & CH_MASK;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      pattern <= '0;
      wcnt    <= '0;
    end else begin
      state   <= nstate;
      pattern <= pat_nx;
      wcnt    <= wcnt_nx;
    end
  end

  always_comb begin
    nstate  = state;
    pat_nx  = pattern;
    wcnt_nx = wcnt;
    case (state)
      IDLE, EVAL: begin
        if (|mhit) begin
          nstate  = (WINDOW == 1) ? EVAL : OPEN;
          pat_nx  = mhit;
          wcnt_nx = WCW'(WINDOW - 1);
        end else begin
          nstate  = IDLE;
          pat_nx  = '0;
        end
      end
      OPEN: begin
        pat_nx  = pattern | mhit;
        wcnt_nx = wcnt - WCW'(1);
        if (wcnt == WCW'(1)) nstate = EVAL;
      end
      default: nstate = IDLE;
    endcase
    if (!booted) nstate = IDLE;
  end

  always_comb begin
    coinc = 1'b0;
    if (state == EVAL && int'(popcount(POP_MAX'(pattern))) >= MIN_FOLD) coinc = 1'b1;
  end

  assign COINC = coinc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     COINC_PAT <= '0;
    else if (coinc) COINC_PAT <= pattern;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                        coinc_cnt <= '0;
    else if (CLR)                      coinc_cnt <= '0;
    else if (coinc && coinc_cnt != '1) coinc_cnt <= coinc_cnt + CNT_W'(1);
  end

  // Out-of-range selects read as zero.
  logic [CNT_W-1:0] rd_nx;

  always_comb begin
    rd_nx = '0;
    for (int i = 0; i < N_CH; i++)
      if (RD_SEL == SEL_W'(i)) rd_nx = cnt[i];
    if (RD_SEL == SEL_W'(N_CH)) rd_nx = coinc_cnt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) RD_DATA <= '0;
    else        RD_DATA <= rd_nx;
  end

endmodule

// File: tb/tb_mppc_coinc_counter.sv
// Directed bench for mppc_coinc_counter (N_CH=8, CNT_W=4, WINDOW=8, MIN_FOLD=2, BOOT_W=5).
module tb_mppc_coinc_counter;

  logic       CLK;
  logic       RST_N;
  logic [7:0] CH_IN, CH_MASK;
  logic       CLR;
  logic [3:0] RD_SEL;
  logic [3:0] RD_DATA;
  logic       DISCHARGE, BOOTED, COINC;
  logic [7:0] HIT, COINC_PAT;

  int n_chk = 0;
  int n_bad = 0;
  int coinc_seen = 0;
  int c0;

  mppc_coinc_counter #(
    .N_CH(8), .CNT_W(4), .WINDOW(8), .MIN_FOLD(2), .BOOT_W(5), .DEAD_CYC(16)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CH_IN(CH_IN), .CH_MASK(CH_MASK), .CLR(CLR),
    .RD_SEL(RD_SEL), .RD_DATA(RD_DATA), .DISCHARGE(DISCHARGE), .BOOTED(BOOTED),
    .HIT(HIT), .COINC(COINC), .COINC_PAT(COINC_PAT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (COINC === 1'b1) coinc_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse(input int ch, input int gap);
    CH_IN[ch] = 1'b1;
    step(2);
    CH_IN[ch] = 1'b0;
    step(gap);
  endtask

  initial begin
    RST_N = 1'b0; CH_IN = '0; CH_MASK = '0; CLR = 1'b0; RD_SEL = '0;
    step(2);
    chk("rst_dis",   32'(DISCHARGE), 1);
    chk("rst_boot",  32'(BOOTED),    0);
    chk("rst_hit",   32'(HIT),       0);
    chk("rst_coinc", 32'(COINC),     0);
    chk("rst_pat",   32'(COINC_PAT), 0);
    chk("rst_rd",    32'(RD_DATA),   0);

    // Boot: 16 cycles of discharge, input activity ignored
    RST_N = 1'b1;
    step(3); CH_IN = 8'h09;
    step(3); CH_IN = '0;
    step(9);
    chk("boot_dis15",  32'(DISCHARGE), 1);
    chk("boot_bt15",   32'(BOOTED),    0);
    chk("boot_hit",    32'(HIT),       0);
    step(1);
    chk("boot_dis16",  32'(DISCHARGE), 0);
    chk("boot_bt16",   32'(BOOTED),    1);
    RD_SEL = 4'd0; step(1);
    chk("boot_cnt0",   32'(RD_DATA), 0);
    RD_SEL = 4'd3; step(1);
    chk("boot_cnt3",   32'(RD_DATA), 0);

    // HIT latency 3, level input gives a single HIT
    CH_IN[0] = 1'b1;
    step(2); chk("lat_t2", 32'(HIT), 0);
    step(1); chk("lat_t3", 32'(HIT), 1);
    step(1); chk("lat_t4", 32'(HIT), 0);
    step(4); chk("lat_hold", 32'(HIT), 0);
    CH_IN[0] = 1'b0; step(2);
    repeat (4) pulse(0, 3);
    step(4);
    RD_SEL = 4'd0; step(1); chk("cnt0_5",   32'(RD_DATA), 5);
    RD_SEL = 4'd9; step(1); chk("rd_oob",   32'(RD_DATA), 0);
    RD_SEL = 4'd8; step(1); chk("coinc_c0", 32'(RD_DATA), 0);

    // CH0 then CH3 four cycles later inside one window
    CH_MASK = 8'hFF;
    c0 = coinc_seen;
    CH_IN = 8'h01; step(4);
    CH_IN = 8'h09; step(4);
    CH_IN = 8'h00; step(3);
    chk("co_pulse", 32'(COINC), 1);
    step(1);
    chk("co_end",   32'(COINC), 0);
    chk("co_pat",   32'(COINC_PAT), 9);
    RD_SEL = 4'd8; step(1);
    chk("co_cnt",   32'(RD_DATA), 1);
    chk("co_once",  32'(coinc_seen - c0), 1);
    step(10);

    // Same with CH3 masked out
    CH_MASK = 8'hF7;
    c0 = coinc_seen;
    CH_IN = 8'h01; step(4);
    CH_IN = 8'h09; step(4);
    CH_IN = 8'h00; step(20);
    chk("mask_none", 32'(coinc_seen - c0), 0);
    chk("mask_pat",  32'(COINC_PAT), 9);
    step(1);
    chk("mask_cnt",  32'(RD_DATA), 1);

    // Hits 10 cycles apart fall in different windows
    CH_MASK = 8'hFF;
    c0 = coinc_seen;
    CH_IN = 8'h01; step(2); CH_IN = '0; step(8);
    CH_IN = 8'h02; step(2); CH_IN = '0; step(30);
    chk("gap_none", 32'(coinc_seen - c0), 0);

    // One channel hitting three times is still a single fold
    c0 = coinc_seen;
    repeat (3) begin
      CH_IN = 8'h04; step(2); CH_IN = '0; step(1);
    end
    step(25);
    chk("rep_none", 32'(coinc_seen - c0), 0);
    RD_SEL = 4'd2; step(1);
    chk("rep_cnt2", 32'(RD_DATA), 3);

    // Saturation at 15 and clear winning over a hit
    CH_MASK = '0;
    repeat (20) pulse(5, 2);
    step(4);
    RD_SEL = 4'd5; step(1);
    chk("sat_15", 32'(RD_DATA), 15);
    CH_IN[5] = 1'b1; step(3);
    chk("clr_hit", 32'(HIT), 32'h20);
    CLR = 1'b1; step(1);
    CLR = 1'b0; CH_IN = '0; step(1);
    chk("clr_c5", 32'(RD_DATA), 0);
    RD_SEL = 4'd0; step(1); chk("clr_c0", 32'(RD_DATA), 0);
    RD_SEL = 4'd8; step(1); chk("clr_co", 32'(RD_DATA), 0);

    // Two CH1 edges 8 cycles apart, then 20 cycles apart
    CH_IN = 8'h02; step(2); CH_IN = '0; step(6);
    CH_IN = 8'h02; step(2); CH_IN = '0; step(10);
    RD_SEL = 4'd1; step(1);
`ifdef MPPC_DEADTIME_EN
    chk("dead_8",  32'(RD_DATA), 1);
`else
    chk("dead_8",  32'(RD_DATA), 2);
`endif
    step(20);
    CLR = 1'b1; step(1); CLR = 1'b0;
    CH_IN = 8'h02; step(2); CH_IN = '0; step(18);
    CH_IN = 8'h02; step(2); CH_IN = '0; step(6);
    chk("dead_20", 32'(RD_DATA), 2);

    // Asynchronous reset mid-run reruns boot
    RST_N = 1'b0; #1;
    chk("mrst_dis",  32'(DISCHARGE), 1);
    chk("mrst_boot", 32'(BOOTED),    0);
    chk("mrst_rd",   32'(RD_DATA),   0);
    step(1); RST_N = 1'b1;
    step(15); chk("mrst_bt15", 32'(BOOTED), 0);
    step(1);  chk("mrst_bt16", 32'(BOOTED), 1);
    RD_SEL = 4'd1; step(1);
    chk("mrst_cnt1", 32'(RD_DATA), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
